// File: rtl/mmss_timer_pkg.sv
// Shared constants and helpers for the MM:SS timer core.
package mmss_timer_pkg;

   // FSM state encoding (3-bit)
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_RUN   = 3'd1;
   localparam logic [2:0] ST_PAUSE = 3'd2;
   localparam logic [2:0] ST_DONE  = 3'd3;
   localparam logic [2:0] ST_ERR   = 3'd4;

   // Display code for a dash on seven_segment
   localparam logic [3:0] DIGIT_DASH   = 4'd10;
   localparam logic [3:0] BCD_MAX_ONES = 4'd9;
   localparam logic [3:0] BCD_MAX_TENS = 4'd5;

   // Nibble positions inside a 16-bit MM:SS word
   localparam int unsigned POS_MT = 12;
   localparam int unsigned POS_MO = 8;
   localparam int unsigned POS_ST = 4;
   localparam int unsigned POS_SO = 0;

   localparam logic [15:0] TIME_ZERO = 16'h0000;
   localparam logic [15:0] TIME_MAX  = 16'h5959;

   // A preset is loadable only if it is a legal MM:SS BCD value
   function automatic logic preset_valid(input logic [15:0] p);
      return (p[POS_MT +: 4] <= BCD_MAX_TENS) &&
             (p[POS_MO +: 4] <= BCD_MAX_ONES) &&
             (p[POS_ST +: 4] <= BCD_MAX_TENS) &&
             (p[POS_SO +: 4] <= BCD_MAX_ONES);
   endfunction

endpackage

// File: rtl/bcd_mmss_step.sv
// One-second BCD step of an MM:SS value, up or down, saturating at the limit.
module bcd_mmss_step
   import mmss_timer_pkg::*;
(
   input  logic [15:0] time_i,
   input  logic        dir_i,
   output logic [15:0] next_o,
   output logic        at_limit_o
);

   logic [3:0] mt, mo, st, so;
   logic       lim;

   assign mt = time_i[POS_MT +: 4];
   assign mo = time_i[POS_MO +: 4];
   assign st = time_i[POS_ST +: 4];
   assign so = time_i[POS_SO +: 4];

   // Ripple carry/borrow through the four digits; hold when already at the limit
   always_comb begin
      lim    = dir_i ? (time_i == TIME_MAX) : (time_i == TIME_ZERO);
      next_o = time_i;
      if (!lim) begin
         if (dir_i) begin
            if (so != BCD_MAX_ONES) begin
               next_o[POS_SO +: 4] = so + 4'd1;
            end else begin
               next_o[POS_SO +: 4] = '0;
               if (st != BCD_MAX_TENS) begin
                  next_o[POS_ST +: 4] = st + 4'd1;
               end else begin
                  next_o[POS_ST +: 4] = '0;
                  if (mo != BCD_MAX_ONES) begin
                     next_o[POS_MO +: 4] = mo + 4'd1;
                  end else begin
                     next_o[POS_MO +: 4] = '0;
                     next_o[POS_MT +: 4] = mt + 4'd1;
                  end
               end
            end
         end else begin
            if (so != 4'd0) begin
               next_o[POS_SO +: 4] = so - 4'd1;
            end else begin
               next_o[POS_SO +: 4] = BCD_MAX_ONES;
               if (st != 4'd0) begin
                  next_o[POS_ST +: 4] = st - 4'd1;
               end else begin
                  next_o[POS_ST +: 4] = BCD_MAX_TENS;
                  if (mo != 4'd0) begin
                     next_o[POS_MO +: 4] = mo - 4'd1;
                  end else begin
                     next_o[POS_MO +: 4] = BCD_MAX_ONES;
                     next_o[POS_MT +: 4] = mt - 4'd1;
                  end
               end
            end
         end
      end
   end

   assign at_limit_o = lim;

endmodule

// File: rtl/mmss_timer_ctrl.sv
// MM:SS countdown/count-up timer core feeding the four seven-segment digits.
module mmss_timer_ctrl
   import mmss_timer_pkg::*;
#(
   parameter int unsigned TICK_DIV = 100_000_000
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        start_db,
   input  logic        load_db,
   input  logic        dir,
   input  logic [15:0] preset,
   output logic [3:0]  digit_0,
   output logic [3:0]  digit_1,
   output logic [3:0]  digit_2,
   output logic [3:0]  digit_3,
   output logic        running,
   output logic        done,
   output logic        err
);

   localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   logic [2:0]    state_q, state_d;
   logic [15:0]   time_q, time_d;
   logic [15:0]   reload_q, reload_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          dir_lat_q, dir_lat_d;
   logic          start_prev_q, load_prev_q;

   logic          start_ev, load_ev, tick;
   logic          step_dir, step_lim, next_lim;
   logic [15:0]   step_next;

   assign start_ev = start_db & ~start_prev_q;
   assign load_ev  = load_db  & ~load_prev_q;
   assign tick     = (state_q == ST_RUN) && (presc_q == PRESC_LAST);

   // In IDLE the step block checks the live dir for the start test; otherwise the latched one
   assign step_dir = (state_q == ST_IDLE) ? dir : dir_lat_q;
   assign next_lim = (step_next == (dir_lat_q ? TIME_MAX : TIME_ZERO));

   bcd_mmss_step u_step (
      .time_i     (time_q),
      .dir_i      (step_dir),
      .next_o     (step_next),
      .at_limit_o (step_lim)
   );

   // Next-state logic: start events take precedence over a same-cycle load
   always_comb begin
      state_d   = state_q;
      time_d    = time_q;
      reload_d  = reload_q;
      presc_d   = presc_q;
      dir_lat_d = dir_lat_q;
      case (state_q)
         ST_IDLE: begin
            if (start_ev) begin
               dir_lat_d = dir;
               presc_d   = '0;
               state_d   = step_lim ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (start_ev) begin
               state_d = ST_PAUSE;
            end else if (tick) begin
               presc_d = '0;
               time_d  = step_next;
               if (next_lim) state_d = ST_DONE;
            end else begin
               presc_d = presc_q + PW'(1);
            end
         end
         ST_PAUSE: begin
            if (start_ev) state_d = ST_RUN;
         end
         ST_DONE: begin
            if (start_ev) begin
               state_d = ST_IDLE;
               time_d  = reload_q;
            end
         end
         ST_ERR: begin
         end
         default: state_d = ST_IDLE;
      endcase
      if (load_ev && !start_ev && (state_q != ST_RUN)) begin
         if (preset_valid(preset)) begin
            time_d   = preset;
            reload_d = preset;
            state_d  = ST_IDLE;
            presc_d  = '0;
         end else begin
            state_d  = ST_ERR;
         end
      end
   end

   // State registers; prev flops reset high so a held button yields no event
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         time_q       <= '0;
         reload_q     <= '0;
         presc_q      <= '0;
         dir_lat_q    <= 1'b0;
         start_prev_q <= 1'b1;
         load_prev_q  <= 1'b1;
      end else begin
         state_q      <= state_d;
         time_q       <= time_d;
         reload_q     <= reload_d;
         presc_q      <= presc_d;
         dir_lat_q    <= dir_lat_d;
         start_prev_q <= start_db;
         load_prev_q  <= load_db;
      end
   end

   assign digit_0 = (state_q == ST_ERR) ? DIGIT_DASH : time_q[POS_SO +: 4];
   assign digit_1 = (state_q == ST_ERR) ? DIGIT_DASH : time_q[POS_ST +: 4];
   assign digit_2 = (state_q == ST_ERR) ? DIGIT_DASH : time_q[POS_MO +: 4];
   assign digit_3 = (state_q == ST_ERR) ? DIGIT_DASH : time_q[POS_MT +: 4];

   assign running = (state_q == ST_RUN);
   assign done    = (state_q == ST_DONE);
   assign err     = (state_q == ST_ERR);

endmodule

// File: tb/tb_mmss_timer_ctrl.sv
// Scoreboard bench for mmss_timer_ctrl with TICK_DIV=4.
module tb_mmss_timer_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_db = 1'b1;
   logic        load_db = 1'b0;
   logic        dir = 1'b0;
   logic [15:0] preset = 16'h0000;
   logic [3:0]  digit_0, digit_1, digit_2, digit_3;
   logic        running, done, err;

   int total = 0;
   int bad = 0;
   logic [18:0] sb[$];
   logic [18:0] e;

   mmss_timer_ctrl #(.TICK_DIV(4)) dut (
      .clk(clk), .rst(rst), .start_db(start_db), .load_db(load_db),
      .dir(dir), .preset(preset),
      .digit_0(digit_0), .digit_1(digit_1), .digit_2(digit_2), .digit_3(digit_3),
      .running(running), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [18:0] mk(input logic [15:0] d, input logic r, input logic dn, input logic er);
      return {d, r, dn, er};
   endfunction

   function automatic logic [18:0] obs();
      return {digit_3, digit_2, digit_1, digit_0, running, done, err};
   endfunction

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press_start();
      start_db = 1'b1; cyc(1); start_db = 1'b0; cyc(1);
   endtask

   task automatic press_load(input logic [15:0] p);
      preset = p; load_db = 1'b1; cyc(1); load_db = 1'b0; cyc(1);
   endtask

   task automatic test_reset();
      sb.push_back(mk(16'h0000, 0, 0, 0));
      cyc(2);
      e = sb.pop_front(); total++;
      if (obs() !== e) begin bad++; $display("FAIL reset_state got=%h want=%h", obs(), e); end
      rst = 1'b0;
      sb.push_back(mk(16'h0000, 0, 0, 0));
      cyc(3);
      e = sb.pop_front(); total++;
      if (obs() !== e) begin bad++; $display("FAIL held_no_event got=%h want=%h", obs(), e); end
      start_db = 1'b0; cyc(1);
      press_start();
      sb.push_back(mk(16'h0000, 0, 1, 0));
      e = sb.pop_front(); total++;
      if (obs() !== e) begin bad++; $display("FAIL repress_event got=%h want=%h", obs(), e); end
   endtask

   task automatic test_countdown();
      dir = 1'b0;
      press_load(16'h0003);
      sb.push_back(mk(16'h0003, 0, 0, 0));
      e = sb.pop_front(); total++;
      if (obs() !== e) begin bad++; $display("FAIL load_0003 got=%h want=%h", obs(), e); end
      press_start();
      sb.push_back(mk(16'h0003, 1, 0, 0));
      sb.push_back(mk(16'h0003, 1, 0, 0));
      sb.push_back(mk(16'h0002, 1, 0, 0));
      sb.push_back(mk(16'h0001, 1, 0, 0));
      sb.push_back(mk(16'h0000, 0, 1, 0));
      e = sb.pop_front(); total++;
      if (obs() !== e) begin bad++; $display("FAIL cnt_start got=%h want=%h", obs(), e); end
      cyc(2);
      e = sb.pop_front(); total++;
      if (obs() !== e) begin bad++; $display("FAIL cnt_pretick got=%h want=%h", obs(), e); end
      cyc(1);
      e = sb.pop_front(); total++;
      if (obs() !== e) begin bad++; $display("FAIL cnt_0002 got=%h want=%h", obs(), e); end
      cyc(4);
      e = sb.pop_front(); total++;
      if (obs() !== e) begin bad++; $display("FAIL cnt_0001 got=%h want=%h", obs(), e); end
      cyc(4);
      e = sb.pop_front(); total++;
      if (obs() !== e) begin bad++; $display("FAIL cnt_done got=%h want=%h", obs(), e); end
   endtask

   task automatic test_borrow_pause();
      dir = 1'b0;
      press_load(16'h0100);
      press_start();
      sb.push_back(mk(16'h0059, 1, 0, 0));
      cyc(3);
      e = sb.pop_front(); total++;
      if (obs() !== e) begin bad++; $display("FAIL borrow_0059 got=%h want=%h", obs(), e); end
      cyc(1);
      dir = 1'b1;
      press_start();
      sb.push_back(mk(16'h0059, 0, 0, 0));
      sb.push_back(mk(16'h0059, 0, 0, 0));
      e = sb.pop_front(); total++;
      if (obs() !== e) begin bad++; $display("FAIL pause_enter got=%h want=%h", obs(), e); end
      cyc(10);
      e = sb.pop_front(); total++;
      if (obs() !== e) begin bad++; $display("FAIL pause_frozen got=%h want=%h", obs(), e); end
      press_start();
      sb.push_back(mk(16'h0059, 1, 0, 0));
      sb.push_back(mk(16'h0059, 1, 0, 0));
      sb.push_back(mk(16'h0058, 1, 0, 0));
      e = sb.pop_front(); total++;
      if (obs() !== e) begin bad++; $display("FAIL resume_run got=%h want=%h", obs(), e); end
      cyc(1);
      e = sb.pop_front(); total++;
      if (obs() !== e) begin bad++; $display("FAIL resume_pretick got=%h want=%h", obs(), e); end
      cyc(1);
      e = sb.pop_front(); total++;
      if (obs() !== e) begin bad++; $display("FAIL resume_tick got=%h want=%h", obs(), e); end
      press_start();
      dir = 1'b0;
   endtask

   task automatic test_count_up();
      dir = 1'b1;
      press_load(16'h5958);
      press_start();
      sb.push_back(mk(16'h5958, 1, 0, 0));
      sb.push_back(mk(16'h5959, 0, 1, 0));
      sb.push_back(mk(16'h5959, 0, 1, 0));
      cyc(2);
      e = sb.pop_front(); total++;
      if (obs() !== e) begin bad++; $display("FAIL up_pretick got=%h want=%h", obs(), e); end
      cyc(1);
      e = sb.pop_front(); total++;
      if (obs() !== e) begin bad++; $display("FAIL up_5959_done got=%h want=%h", obs(), e); end
      cyc(6);
      e = sb.pop_front(); total++;
      if (obs() !== e) begin bad++; $display("FAIL up_no_wrap got=%h want=%h", obs(), e); end
      press_start();
      sb.push_back(mk(16'h5958, 0, 0, 0));
      e = sb.pop_front(); total++;
      if (obs() !== e) begin bad++; $display("FAIL done_reload got=%h want=%h", obs(), e); end
      dir = 1'b0;
   endtask

   task automatic test_invalid_preset();
      press_load(16'h0a00);
      sb.push_back(mk(16'haaaa, 0, 0, 1));
      sb.push_back(mk(16'haaaa, 0, 0, 1));
      sb.push_back(mk(16'haaaa, 0, 0, 1));
      sb.push_back(mk(16'h1234, 0, 0, 0));
      e = sb.pop_front(); total++;
      if (obs() !== e) begin bad++; $display("FAIL err_nibble got=%h want=%h", obs(), e); end
      press_start();
      e = sb.pop_front(); total++;
      if (obs() !== e) begin bad++; $display("FAIL err_start_ign got=%h want=%h", obs(), e); end
      press_load(16'h0060);
      e = sb.pop_front(); total++;
      if (obs() !== e) begin bad++; $display("FAIL err_stens got=%h want=%h", obs(), e); end
      press_load(16'h1234);
      e = sb.pop_front(); total++;
      if (obs() !== e) begin bad++; $display("FAIL err_exit got=%h want=%h", obs(), e); end
   endtask

   task automatic test_back_to_back();
      dir = 1'b0;
      press_load(16'h0009);
      preset = 16'h0005;
      start_db = 1'b1; load_db = 1'b1;
      sb.push_back(mk(16'h0009, 1, 0, 0));
      sb.push_back(mk(16'h0009, 1, 0, 0));
      sb.push_back(mk(16'h0009, 1, 0, 0));
      sb.push_back(mk(16'h0008, 1, 0, 0));
      cyc(1);
      e = sb.pop_front(); total++;
      if (obs() !== e) begin bad++; $display("FAIL prio_start got=%h want=%h", obs(), e); end
      start_db = 1'b0; load_db = 1'b0; cyc(1);
      load_db = 1'b1; cyc(1); load_db = 1'b0;
      e = sb.pop_front(); total++;
      if (obs() !== e) begin bad++; $display("FAIL run_load_ign got=%h want=%h", obs(), e); end
      cyc(1);
      e = sb.pop_front(); total++;
      if (obs() !== e) begin bad++; $display("FAIL prio_pretick got=%h want=%h", obs(), e); end
      cyc(1);
      e = sb.pop_front(); total++;
      if (obs() !== e) begin bad++; $display("FAIL prio_tick got=%h want=%h", obs(), e); end
      press_start();
   endtask

   task automatic test_zero_and_reset();
      dir = 1'b0;
      press_load(16'h0000);
      press_start();
      sb.push_back(mk(16'h0000, 0, 1, 0));
      sb.push_back(mk(16'h0000, 0, 1, 0));
      e = sb.pop_front(); total++;
      if (obs() !== e) begin bad++; $display("FAIL zero_done got=%h want=%h", obs(), e); end
      cyc(3);
      e = sb.pop_front(); total++;
      if (obs() !== e) begin bad++; $display("FAIL zero_hold got=%h want=%h", obs(), e); end
      press_load(16'h0005);
      press_start();
      cyc(2);
      rst = 1'b1;
      sb.push_back(mk(16'h0000, 0, 0, 0));
      sb.push_back(mk(16'h0000, 0, 0, 0));
      sb.push_back(mk(16'h0000, 0, 1, 0));
      #1;
      e = sb.pop_front(); total++;
      if (obs() !== e) begin bad++; $display("FAIL async_rst got=%h want=%h", obs(), e); end
      cyc(1);
      rst = 1'b0;
      cyc(1);
      e = sb.pop_front(); total++;
      if (obs() !== e) begin bad++; $display("FAIL post_rst_idle got=%h want=%h", obs(), e); end
      press_start();
      e = sb.pop_front(); total++;
      if (obs() !== e) begin bad++; $display("FAIL post_rst_start got=%h want=%h", obs(), e); end
   endtask

   initial begin
      test_reset();
      test_countdown();
      test_borrow_pause();
      test_count_up();
      test_invalid_preset();
      test_back_to_back();
      test_zero_and_reset();
      if (sb.size() != 0) begin
         total++; bad++;
         $display("FAIL sb_leftover got=%0d want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1, "timeout");
   end

endmodule
